column_parity_engine: RTL and testbench

COLUMN_PARITY_ENGINE -- requirements
Module: column_parity_engine

---
 rtl/column_parity_pkg.sv | 21 ++
 rtl/column_parity.sv | 18 +
 rtl/column_parity_engine.sv | 158 +++++++++++++++
 tb/tb_column_parity_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/column_parity_pkg.sv
// Shared encodings for the column parity engine: command modes and sweep FSM states.
package column_parity_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_PAR1  = 3'b001,
    MODE_PAR2  = 3'b010,
    MODE_INC   = 3'b011,
    MODE_SHL   = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_SWEEP = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/column_parity.sv
// Column parity: bit k of par is the XOR of bit k across all N packed words.
module column_parity #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic [N*W-1:0] words,
  output logic [W-1:0]   par
);

  // XOR-fold the N words together; each column reduces to its parity.
  always_comb begin
    par = '0;
    for (int c = 0; c < N; c++) begin
      par = par ^ words[c*W +: W];
    end
  end

endmodule

// File: rtl/column_parity_engine.sv
// Column parity engine: single-shot parity/arith commands on a W-bit result
// register, plus a multi-cycle SWEEP that rebuilds out one column per edge
// from a snapshot of the inputs taken at accept time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; in_valid accepted here only
// ST_SWEEP | writing out[k] from shadow parity, one bit per edge
// ST_DONE  | one-cycle completion pulse (done=1), then back to IDLE
module column_parity_engine
  import column_parity_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int SHIFT = 2,
  parameter bit SAT   = 1'b0,
  localparam int CW   = (N > 1) ? $clog2(N) : 1,
  localparam int SW   = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_flat,
  input  logic           in_valid,
  input  logic [2:0]     ctrl_mode,
  input  logic [CW-1:0]  ctrl_ch,
  input  logic [SW-1:0]  ctrl_sel,
  output logic [W-1:0]   out,
  output logic           busy,
  output logic           done,
  output logic           out_upd
);

  localparam logic [SW-1:0] K_LAST = SW'(W - 1);

  sweep_state_e   state_q, state_d;
  logic [W-1:0]   out_d;
  logic           upd_d;
  logic [SW-1:0]  k_q, k_d;
  logic [N*W-1:0] shadow_q, shadow_d;
  logic [W-1:0]   par_live, par_shadow;
  logic [W-1:0]   words [N];
  logic [W-1:0]   sel_word;
  logic [SW-1:0]  sel_m1;
  logic           ch_ok, sel_ok, accept;

  column_parity #(.N(N), .W(W)) u_par_live   (.words(in_flat),  .par(par_live));
  column_parity #(.N(N), .W(W)) u_par_shadow (.words(shadow_q), .par(par_shadow));

  // Unpack channels; out-of-range indices fall back to channel 0 (unused then).
  always_comb begin
    for (int c = 0; c < N; c++) begin
      words[c] = in_flat[c*W +: W];
    end
    ch_ok    = 32'(ctrl_ch) < N;
    sel_ok   = 32'(ctrl_sel) < W;
    sel_word = words[ch_ok ? ctrl_ch : '0];
    sel_m1   = ctrl_sel - SW'(1);
    accept   = in_valid && !busy;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a well-formed SWEEP starts the walk, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && ctrl_mode == MODE_SWEEP && ch_ok && sel_ok) state_d = ST_SWEEP;
      ST_SWEEP: if (k_q == K_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: anything other than IDLE blocks new commands.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath next values; out_upd flags every edge that writes out.
  always_comb begin
    out_d    = out;
    upd_d    = 1'b0;
    k_d      = k_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_SWEEP: begin
        out_d[k_q] = par_shadow[k_q];
        upd_d      = 1'b1;
        k_d        = (k_q == K_LAST) ? '0 : k_q + SW'(1);
      end
      ST_IDLE: begin
        if (accept) begin
          case (mode_e'(ctrl_mode))
            MODE_PAR1: begin
              if (ch_ok && sel_ok) begin
                out_d           = sel_word;
                out_d[ctrl_sel] = par_live[ctrl_sel];
                upd_d           = 1'b1;
              end
            end
            MODE_PAR2: begin
              if (ch_ok && sel_ok) begin
                out_d           = sel_word;
                out_d[ctrl_sel] = par_live[ctrl_sel];
                if (ctrl_sel != '0) out_d[sel_m1] = par_live[sel_m1];
                upd_d           = 1'b1;
              end
            end
            MODE_INC: begin
              // Saturated INC still counts as a write of the same value.
              if (!(SAT && (&out))) out_d = out + W'(1);
              upd_d = 1'b1;
            end
            MODE_SHL: begin
              out_d = out << SHIFT;
              upd_d = 1'b1;
            end
            MODE_ROTL: begin
              out_d = (out << SHIFT) | (out >> (W - SHIFT));
              upd_d = 1'b1;
            end
            MODE_SWEEP: begin
              if (ch_ok && sel_ok) begin
                shadow_d = in_flat;
                out_d    = sel_word;
                k_d      = '0;
                upd_d    = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      out_upd  <= 1'b0;
      k_q      <= '0;
      shadow_q <= '0;
    end else begin
      out      <= out_d;
      out_upd  <= upd_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_column_parity_engine.sv
// Bench for column_parity_engine: vector table, hand-written sweep/reset
// sequences, an N=3/W=5/SAT=1 instance, and randomized traffic vs a model.
module tb_column_parity_engine;

  localparam int N = 4, W = 4, SHIFT = 2;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, in_valid, busy, done, out_upd;
  logic [15:0] in_flat;
  logic [2:0]  ctrl_mode;
  logic [1:0]  ctrl_ch, ctrl_sel;
  logic [3:0]  out;

  // N=3, W=5, SAT=1 instance
  logic        a_rst, a_valid, a_busy, a_done, a_upd;
  logic [14:0] a_flat;
  logic [2:0]  a_mode;
  logic [1:0]  a_ch;
  logic [2:0]  a_sel;
  logic [4:0]  a_out;

  column_parity_engine #(.N(N), .W(W), .SHIFT(SHIFT), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .in_valid(in_valid),
    .ctrl_mode(ctrl_mode), .ctrl_ch(ctrl_ch), .ctrl_sel(ctrl_sel),
    .out(out), .busy(busy), .done(done), .out_upd(out_upd));

  column_parity_engine #(.N(3), .W(5), .SHIFT(2), .SAT(1'b1)) dut_alt (
    .clk(clk), .rst(a_rst), .in_flat(a_flat), .in_valid(a_valid),
    .ctrl_mode(a_mode), .ctrl_ch(a_ch), .ctrl_sel(a_sel),
    .out(a_out), .busy(a_busy), .done(a_done), .out_upd(a_upd));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] m,
                       input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] fl);
    rst = r; in_valid = v; ctrl_mode = m; ctrl_ch = ch; ctrl_sel = sel; in_flat = fl;
  endtask

  task automatic chk4(input string nm, input int e_out, input int e_upd, input int e_busy, input int e_done);
    check({nm, ".out"},  32'(out),     e_out);
    check({nm, ".upd"},  32'(out_upd), e_upd);
    check({nm, ".busy"}, 32'(busy),    e_busy);
    check({nm, ".done"}, 32'(done),    e_done);
  endtask

  task automatic adrive(input logic v, input logic [2:0] m, input logic [1:0] ch, input logic [2:0] sel);
    a_valid = v; a_mode = m; a_ch = ch; a_sel = sel;
  endtask

  // ---------------- reference model ----------------
  int m_out, m_upd, m_phase, m_shadow;

  function automatic int par_of(input int flat);
    int p, s;
    p = 0;
    for (int k = 0; k < W; k++) begin
      s = 0;
      for (int c = 0; c < N; c++) s += (flat >> (c*W + k)) & 1;
      p |= (s % 2) << k;
    end
    return p;
  endfunction

  function automatic int setbit(input int v, input int k, input int b);
    return (v & ~(1 << k)) | ((b & 1) << k);
  endfunction

  // m_phase: 0 idle, 1..W sweep edges pending (bit m_phase-1 next), W+1 done cycle
  task automatic model_step();
    int p, w, s;
    if (rst) begin
      m_out = 0; m_upd = 0; m_phase = 0; m_shadow = 0;
    end else if (m_phase != 0) begin
      m_upd = 0;
      if (m_phase <= W) begin
        p = par_of(m_shadow);
        m_out = setbit(m_out, m_phase - 1, p >> (m_phase - 1));
        m_upd = 1;
      end
      m_phase = (m_phase == W + 1) ? 0 : m_phase + 1;
    end else begin
      m_upd = 0;
      if (in_valid) begin
        p = par_of(int'(in_flat));
        w = (int'(in_flat) >> (int'(ctrl_ch) * W)) & MASK;
        s = int'(ctrl_sel);
        case (ctrl_mode)
          3'd1: begin m_out = setbit(w, s, p >> s); m_upd = 1; end
          3'd2: begin
            m_out = setbit(w, s, p >> s);
            if (s > 0) m_out = setbit(m_out, s - 1, p >> (s - 1));
            m_upd = 1;
          end
          3'd3: begin m_out = (m_out + 1) % (1 << W); m_upd = 1; end
          3'd4: begin m_out = (m_out << SHIFT) & MASK; m_upd = 1; end
          3'd5: begin m_out = ((m_out << SHIFT) | (m_out >> (W - SHIFT))) & MASK; m_upd = 1; end
          3'd6: begin m_shadow = int'(in_flat); m_out = w; m_phase = 1; m_upd = 1; end
          default: ;
        endcase
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r, v;
    logic [2:0]  m;
    logic [1:0]  ch, sel;
    logic [15:0] flat;
    int          e_out, e_upd, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] m,
                              input logic [1:0] ch, input logic [1:0] sel, input int e_out, input int e_upd);
    vec_t x;
    x.r = r; x.v = v; x.m = m; x.ch = ch; x.sel = sel; x.flat = 16'hE36A;
    x.e_out = e_out; x.e_upd = e_upd; x.e_busy = 0; x.e_done = 0;
    return x;
  endfunction

  initial begin
    // in0=1010 in1=0110 in2=0011 in3=1110, P=0001
    tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0));    // reset
    tbl.push_back(mk(0, 1, 3'd1, 1, 0, 7, 1));    // PAR1 ch1 sel0 -> 0111
    tbl.push_back(mk(0, 0, 3'd1, 0, 1, 7, 0));    // in_valid=0 holds
    tbl.push_back(mk(0, 1, 3'd4, 0, 0, 12, 1));   // SHL 0111 -> 1100
    tbl.push_back(mk(0, 1, 3'd1, 1, 0, 7, 1));    // reload 0111
    tbl.push_back(mk(0, 1, 3'd5, 0, 0, 13, 1));   // ROTL 0111 -> 1101
    tbl.push_back(mk(0, 1, 3'd2, 2, 1, 1, 1));    // PAR2 ch2 sel1 -> 0001
    tbl.push_back(mk(0, 1, 3'd2, 0, 0, 11, 1));   // PAR2 sel0 only bit0 -> 1011
    tbl.push_back(mk(0, 1, 3'd3, 0, 0, 12, 1));   // INC
    tbl.push_back(mk(0, 1, 3'd0, 0, 0, 12, 0));   // HOLD
    tbl.push_back(mk(0, 1, 3'd7, 0, 0, 12, 0));   // reserved = HOLD
    tbl.push_back(mk(0, 1, 3'd1, 3, 0, 15, 1));   // PAR1 ch3 -> 1111
    tbl.push_back(mk(0, 1, 3'd3, 0, 0, 0, 1));    // INC wraps -> 0000

    a_rst = 1'b1; a_flat = '0; adrive(0, 3'd0, 0, 0);
    drive(1, 0, 3'd0, 0, 0, 16'h0);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].m, tbl[i].ch, tbl[i].sel, tbl[i].flat);
      tick();
      chk4($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_upd, tbl[i].e_busy, tbl[i].e_done);
    end

    // SWEEP ch0: snapshot must survive in_flat going to zero; PAR1 while busy ignored
    drive(0, 1, 3'd6, 0, 0, 16'hE36A);
    tick();
    chk4("sweep.accept", 10, 1, 1, 0);
    drive(0, 1, 3'd1, 1, 0, 16'h0000);
    tick(); chk4("sweep.e1", 11, 1, 1, 0);
    tick(); chk4("sweep.e2", 9, 1, 1, 0);
    tick(); chk4("sweep.e3", 9, 1, 1, 0);
    tick(); chk4("sweep.e4", 1, 1, 1, 1);
    tick(); chk4("sweep.e5", 1, 0, 0, 0);
    drive(0, 0, 3'd0, 0, 0, 16'h0);
    tick(); chk4("sweep.idle", 1, 0, 0, 0);

    // reset at the third sweep edge
    drive(0, 1, 3'd6, 0, 0, 16'hE36A);
    tick(); chk4("rsw.accept", 10, 1, 1, 0);
    drive(0, 0, 3'd0, 0, 0, 16'hE36A);
    tick(); chk4("rsw.e1", 11, 1, 1, 0);
    tick(); chk4("rsw.e2", 9, 1, 1, 0);
    drive(1, 0, 3'd0, 0, 0, 16'hE36A);
    tick(); chk4("rsw.rst", 0, 0, 0, 0);
    drive(0, 1, 3'd1, 1, 0, 16'hE36A);
    tick(); chk4("rsw.first", 7, 1, 0, 0);
    drive(0, 0, 3'd4, 0, 0, 16'hE36A);
    tick(); chk4("rsw.novalid", 7, 0, 0, 0);

    // N=3 W=5 SAT=1 instance: ch0=11111, ch1=ch2=0, P=11111
    drive(0, 0, 3'd0, 0, 0, 16'h0);
    a_flat = 15'h001F;
    tick();
    a_rst = 1'b0;
    adrive(1, 3'd1, 0, 0); tick();
    check("alt.par1", 32'(a_out), 31); check("alt.par1.upd", 32'(a_upd), 1);
    adrive(1, 3'd3, 0, 0); tick();
    check("alt.incsat", 32'(a_out), 31); check("alt.incsat.upd", 32'(a_upd), 1);
    adrive(1, 3'd1, 0, 6); tick();
    check("alt.sel6", 32'(a_out), 31); check("alt.sel6.upd", 32'(a_upd), 0);
    adrive(1, 3'd6, 0, 5); tick();
    check("alt.sweepsel5", 32'(a_out), 31); check("alt.sweepsel5.upd", 32'(a_upd), 0);
    check("alt.sweepsel5.busy", 32'(a_busy), 0);
    adrive(1, 3'd2, 3, 0); tick();
    check("alt.ch3", 32'(a_out), 31); check("alt.ch3.upd", 32'(a_upd), 0);
    adrive(1, 3'd1, 1, 4); tick();
    check("alt.par1ch1", 32'(a_out), 16); check("alt.par1ch1.upd", 32'(a_upd), 1);
    adrive(1, 3'd3, 0, 0); tick();
    check("alt.inc", 32'(a_out), 17);
    check("alt.done", 32'(a_done), 0);
    adrive(0, 3'd0, 0, 0);

    // randomized traffic against the model
    drive(1, 0, 3'd0, 0, 0, 16'h0);
    tick(); model_step();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
      tick();
      model_step();
      check("rnd.out",  32'(out),     m_out);
      check("rnd.upd",  32'(out_upd), m_upd);
      check("rnd.busy", 32'(busy),    (m_phase != 0) ? 1 : 0);
      check("rnd.done", 32'(done),    (m_phase == W + 1) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
